// File: rtl/shifter_pkg.sv
// Shared constants and helpers for the EX-stage shifters (left and right).
package shifter_pkg;

  localparam int WIDTH = 32;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;

  // Sideband that travels with the data through the right-shift pipe.
  typedef struct packed {
    logic [2:0] rem;
    logic       fill;
    logic       big;
  } shr_side_t;

  // Right shift by s with the vacated MSBs taken from f.
  function automatic logic [WIDTH-1:0] shr_fill(input logic [WIDTH-1:0] d,
                                                input logic             f,
                                                input int unsigned      s);
    logic [WIDTH:0] t;
    t = $unsigned($signed({f, d}) >>> s);
    return t[WIDTH-1:0];
  endfunction

endpackage

// File: rtl/shifter_right_stage.sv
// One registered stage of the right shifter: two conditional power-of-two
// right shifts with fill, plus valid and sideband registers.
module shifter_right_stage
  import shifter_pkg::*;
#(
  parameter int unsigned SH_HI   = 16,
  parameter int unsigned SH_LO   = 8,
  parameter bit          BIG_OVR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_adv,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       i_sel,
  input  shr_side_t        i_side,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output shr_side_t        o_side
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  shr_side_t        r_side;

  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_hi   = i_sel[1] ? shr_fill(i_data, i_side.fill, SH_HI) : i_data;
    w_lo   = i_sel[0] ? shr_fill(w_hi, i_side.fill, SH_LO) : w_hi;
    // Shift amounts of 32 or more collapse to a full word of fill.
    w_next = (BIG_OVR && i_side.big) ? {WIDTH{i_side.fill}} : w_lo;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_side  <= '0;
    end else if (i_adv) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= w_next;
        r_side <= i_side;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_side  = r_side;

endmodule

// File: rtl/shifter_right_pipe.sv
// Three-stage pipelined 32-bit right barrel shifter (SRL/SRA) with a
// valid/ready handshake; the ready chain lives here, the shift steps in the stages.
module shifter_right_pipe
  import shifter_pkg::*;
#(
  parameter int          WIDTH_P = shifter_pkg::WIDTH,
  parameter logic [5:0]  FN_SRL  = shifter_pkg::FN_SRL,
  parameter logic [5:0]  FN_SRA  = shifter_pkg::FN_SRA
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_P-1:0] inputNum,
  input  logic [WIDTH_P-1:0] move,
  input  logic [5:0]         Signal,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_P-1:0] dataOut
);

  logic             w_is_sra;
  shr_side_t        w_side0;
  logic             w_v1, w_v2, w_v3;
  logic             w_rdy1, w_rdy2, w_rdy3;
  logic [WIDTH-1:0] w_d1, w_d2, w_d3;
  shr_side_t        w_side1, w_side2, w_side3;
  logic             w_unused;

  assign w_is_sra = (Signal == FN_SRA);
  assign w_side0  = '{rem: move[2:0], fill: w_is_sra & inputNum[WIDTH-1], big: |move[31:5]};

  // A stage may load when it is empty or its successor is loading this cycle.
  assign w_rdy3   = !w_v3 || out_ready;
  assign w_rdy2   = !w_v2 || w_rdy3;
  assign w_rdy1   = !w_v1 || w_rdy2;
  assign in_ready = w_rdy1;

  shifter_right_stage #(.SH_HI(16), .SH_LO(8), .BIG_OVR(1'b0)) u_stage1 (
    .clk     (clk),
    .reset   (reset),
    .i_adv   (w_rdy1),
    .i_valid (in_valid),
    .i_data  (inputNum),
    .i_sel   (move[4:3]),
    .i_side  (w_side0),
    .o_valid (w_v1),
    .o_data  (w_d1),
    .o_side  (w_side1)
  );

  shifter_right_stage #(.SH_HI(4), .SH_LO(2), .BIG_OVR(1'b0)) u_stage2 (
    .clk     (clk),
    .reset   (reset),
    .i_adv   (w_rdy2),
    .i_valid (w_v1),
    .i_data  (w_d1),
    .i_sel   (w_side1.rem[2:1]),
    .i_side  (w_side1),
    .o_valid (w_v2),
    .o_data  (w_d2),
    .o_side  (w_side2)
  );

  // Last stage: only the >>1 step is used, then the big-amount override.
  shifter_right_stage #(.SH_HI(1), .SH_LO(0), .BIG_OVR(1'b1)) u_stage3 (
    .clk     (clk),
    .reset   (reset),
    .i_adv   (w_rdy3),
    .i_valid (w_v2),
    .i_data  (w_d2),
    .i_sel   ({w_side2.rem[0], 1'b0}),
    .i_side  (w_side2),
    .o_valid (w_v3),
    .o_data  (w_d3),
    .o_side  (w_side3)
  );

  assign out_valid = w_v3;
  assign dataOut   = w_d3;

  assign w_unused = ^{w_side3, (Signal == FN_SRL), (Signal == FN_SLL), WIDTH_P};

endmodule
